dds_multichannel: RTL and testbench

Multi-channel direct digital synthesiser. It replaces the fixed single-tone 440 Hz sine source with per-channel programmable frequency, phase offset, waveform and amplitude. It uses a quarter-wave sine LUT. Once per audio sample strobe it emits one sample per channel, in order, over a valid/ready stream toward the I2S/audio path. Channels are configured by a simple register write port.

---
 rtl/dds_multichannel.sv | 204 ++++++++++++++++++++
 tb/tb_dds_multichannel.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_multichannel.sv
// Multi-channel direct digital synthesiser.
// Each channel has a phase accumulator and four registers: phase_inc,
// phase_offset, mode and amplitude. Once per sample_tick the accumulators are
// snapshotted and advanced. One sample per channel is then produced in channel
// order on a valid/ready stream.
// Modes: 0 off, 1 quarter-wave LUT sine, 2 square, 3 saw.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   sample_tick            one-cycle strobe per audio sample period
//   cfg_we/chan/addr/wdata register write port
//                          addr 0 inc, 1 offset, 2 mode, 3 amplitude
//   out_valid/out_ready    sample stream handshake
//   out_chan/out_last      channel index / last channel of the frame
//   out_data               signed sample
//   overrun                sticky: a tick arrived while a frame was in progress
module dds_multichannel #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned LUT_ADDR    = 8,
  parameter int unsigned DATA_WIDTH  = 24,
  parameter string       LUT_FILE    = "sin_qlut_256x23.mem"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_chan,
  input  logic [1:0]            cfg_addr,
  input  logic [31:0]           cfg_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            out_chan,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  overrun
);

  localparam int unsigned PW    = PHASE_WIDTH;
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned PRODW = DW + 17;
  localparam logic [2:0]  LAST_CH = 3'(CHANNELS - 1);
  localparam logic signed [DW-1:0] FULL_SCALE = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]        SIGN_BIT   = {1'b1, {(DW-1){1'b0}}};

  if (CHANNELS < 1 || CHANNELS > 8 || PHASE_WIDTH < DATA_WIDTH ||
      PHASE_WIDTH < LUT_ADDR + 2) begin : g_bad_params
    $error("dds_multichannel: unsupported parameter set (table %s)", LUT_FILE);
  end

  // The quarter-wave table holds the same contents LUT_FILE would hold:
  // round((2^(DW-1)-1) * sin(pi/2 * (i+0.5) / 2^LUT_ADDR)).
  // It is built at elaboration with a 48-bit fixed-point Taylor series, so no
  // external memory image is needed.
  function automatic logic [DATA_WIDTH-2:0] sine_entry(input int unsigned idx);
    logic [127:0] x, x2, term, sum, val;
    x    = (128'd884279719003555 * 128'(2 * idx + 1)) >> (LUT_ADDR + 2);
    x2   = (x * x) >> 48;
    term = x;
    sum  = x;
    for (int unsigned k = 1; k < 10; k++) begin
      term = ((term * x2) >> 48) / 128'(2 * k * (2 * k + 1));
      if (k % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    val = (((128'd1 << (DATA_WIDTH - 1)) - 128'd1) * sum + (128'd1 << 47)) >> 48;
    return (DATA_WIDTH-1)'(val);
  endfunction

  logic [DW-2:0] lut [2**LUT_ADDR];
  for (genvar g = 0; g < 2**LUT_ADDR; g++) begin : g_lut
    localparam logic [DATA_WIDTH-2:0] ENTRY = sine_entry(g);
    assign lut[g] = ENTRY;
  end

  typedef enum logic [1:0] {IDLE, LOOKUP, SCALE, EMIT} state_t;
  state_t state, state_next;

  logic [PW-1:0] acc  [CHANNELS];
  logic [PW-1:0] snap [CHANNELS];
  logic [PW-1:0] inc  [CHANNELS];
  logic [PW-1:0] off  [CHANNELS];
  logic [1:0]    mode [CHANNELS];
  logic [15:0]   amp  [CHANNELS];

  logic [2:0]           ch;
  logic [PW-1:0]        wdata_pw;
  logic [PW-1:0]        ph;
  logic [1:0]           cmode;
  logic [15:0]          camp;
  logic [1:0]           quad;
  logic [LUT_ADDR-1:0]  lidx;
  logic [DW-2:0]        mag;
  logic signed [DW-1:0] wave, wave_q;
  logic [15:0]          amp_q;
  logic signed [PRODW-1:0] prod;

  assign wdata_pw  = PW'(cfg_wdata);
  assign out_valid = (state == EMIT);

  // Select the active channel's phase and settings.
  always_comb begin
    ph    = '0;
    cmode = '0;
    camp  = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (ch == 3'(c)) begin
        ph    = snap[c] + off[c];
        cmode = mode[c];
        camp  = amp[c];
      end
    end
  end

  // Waveform generation. Odd quadrants read the table mirrored, and the
  // lower half-cycle is negated.
  always_comb begin
    quad = ph[PW-1 -: 2];
    lidx = quad[0] ? ~ph[PW-3 -: LUT_ADDR] : ph[PW-3 -: LUT_ADDR];
    mag  = lut[lidx];
    wave = '0;
    case (cmode)
      2'd1:    wave = quad[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
      2'd2:    wave = ph[PW-1] ? -FULL_SCALE : FULL_SCALE;
      2'd3:    wave = $signed(DW'(ph >> (PW - DW)) ^ SIGN_BIT);
      default: wave = '0;
    endcase
  end

  assign prod = PRODW'(wave_q) * PRODW'($signed({1'b0, amp_q}));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (sample_tick) state_next = LOOKUP;
      LOOKUP:  state_next = SCALE;
      SCALE:   state_next = EMIT;
      EMIT:    if (out_ready) state_next = (ch == LAST_CH) ? IDLE : LOOKUP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        acc[c]  <= '0;
        snap[c] <= '0;
        inc[c]  <= '0;
        off[c]  <= '0;
        mode[c] <= 2'd1;
        amp[c]  <= '1;
      end
      ch       <= '0;
      wave_q   <= '0;
      amp_q    <= '0;
      out_data <= '0;
      out_chan <= '0;
      out_last <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      // Out-of-range channel numbers match no loop index and are dropped.
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (cfg_we && cfg_chan == 3'(c)) begin
          case (cfg_addr)
            2'd0:    inc[c]  <= wdata_pw;
            2'd1:    off[c]  <= wdata_pw;
            2'd2:    mode[c] <= cfg_wdata[1:0];
            default: amp[c]  <= cfg_wdata[15:0];
          endcase
        end
      end
      if (sample_tick) begin
        if (state == IDLE) begin
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            snap[c] <= acc[c];
            acc[c]  <= acc[c] + inc[c];
          end
        end else begin
          overrun <= 1'b1;
        end
      end
      case (state)
        IDLE: ch <= '0;
        LOOKUP: begin
          // Amplitude is latched here with the waveform. A write that lands
          // after this channel's lookup then cannot alter its sample.
          wave_q <= wave;
          amp_q  <= camp;
        end
        SCALE: begin
          out_data <= DW'(prod >>> 16);
          out_chan <= ch;
          out_last <= (ch == LAST_CH);
        end
        default: if (out_ready && ch != LAST_CH) ch <= ch + 3'd1;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_multichannel.sv
module tb_dds_multichannel;
  localparam int unsigned CH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic        cfg_we;
  logic [2:0]  cfg_chan;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_chan;
  logic        out_last;
  logic [23:0] out_data;
  logic        overrun;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  dds_multichannel #(
    .CHANNELS(CH), .PHASE_WIDTH(32), .LUT_ADDR(8), .DATA_WIDTH(24)
  ) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_last(out_last), .out_data(out_data), .overrun(overrun)
  );

  // Reference model state
  int unsigned m_acc [CH];
  int unsigned m_frame [CH];
  int unsigned m_inc [CH];
  int unsigned m_off [CH];
  int unsigned m_mode [CH];
  int unsigned m_amp [CH];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint lut_ref(input int unsigned i);
    real r;
    r = 8388607.0 * $sin(3.141592653589793 * (real'(i) + 0.5) / 512.0);
    return longint'($rtoi(r + 0.5));
  endfunction

  // Sample value from phase, mode and amplitude, using the waveform
  // definitions directly: sine by quadrant folding of a 1024-step cycle,
  // square by half-cycle, saw as a linear ramp of the upper 24 phase bits.
  function automatic longint model_sample(input int unsigned phase,
                                          input int unsigned mode_v,
                                          input int unsigned amp_v);
    longint w;
    int unsigned n;
    n = phase >> 22;
    case (mode_v)
      1: begin
        w = lut_ref(((n % 512) >= 256) ? 255 - (n % 256) : (n % 256));
        if (n >= 512) w = -w;
      end
      2: w = (phase < 32'h8000_0000) ? 64'sd8388607 : -64'sd8388607;
      3: w = longint'(phase / 256) - 64'sd8388608;
      default: w = 0;
    endcase
    w = (w * longint'(amp_v)) >>> 16;
    return w & 64'hFF_FFFF;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0; m_frame[c] = 0; m_inc[c] = 0; m_off[c] = 0;
      m_mode[c] = 1; m_amp[c] = 32'hFFFF;
    end
  endtask

  task automatic model_write(input int unsigned ch, input int unsigned addr, input int unsigned data);
    if (ch < CH) begin
      case (addr)
        0: m_inc[ch] = data;
        1: m_off[ch] = data;
        2: m_mode[ch] = data & 3;
        default: m_amp[ch] = data & 32'hFFFF;
      endcase
    end
  endtask

  task automatic model_tick();
    for (int c = 0; c < CH; c++) begin
      m_frame[c] = m_acc[c];
      m_acc[c] = m_acc[c] + m_inc[c];
    end
  endtask

  task automatic cfg_write(input int unsigned ch, input int unsigned addr, input int unsigned data);
    cfg_we = 1'b1; cfg_chan = 3'(ch); cfg_addr = 2'(addr); cfg_wdata = data;
    step();
    cfg_we = 1'b0;
    model_write(ch, addr, data);
  endtask

  // Tick, optionally with a same-cycle register write (the tick sees old values).
  task automatic start_frame(input bit wr, input int unsigned ch, input int unsigned addr,
                             input int unsigned data);
    sample_tick = 1'b1;
    if (wr) begin
      cfg_we = 1'b1; cfg_chan = 3'(ch); cfg_addr = 2'(addr); cfg_wdata = data;
    end
    step();
    sample_tick = 1'b0;
    cfg_we = 1'b0;
    model_tick();
    if (wr) model_write(ch, addr, data);
  endtask

  task automatic collect_frame(input bit rand_ready, input bit timing);
    int unsigned idx = 0;
    int unsigned cyc = 0;
    bit seen = 0;
    bit v;
    bit rdy;
    while (idx < CH && cyc < 200) begin
      if (out_valid) begin
        check("data", out_data, model_sample(m_frame[idx] + m_off[idx], m_mode[idx], m_amp[idx]));
        check("chan", out_chan, idx);
        check("last", out_last, (idx == CH - 1) ? 1 : 0);
        if (timing && !seen) check("latency", cyc + 1, 3 + 3 * idx);
        seen = 1;
      end
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      v = out_valid;
      step();
      cyc++;
      if (v && rdy) begin
        idx++;
        seen = 0;
      end
    end
    check("frame_count", idx, CH);
    check("valid_drop", out_valid, 0);
    out_ready = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    check(tag, out_valid, 1);
  endtask

  initial begin
    int extra;
    longint exp0;
    reset = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_chan = '0; cfg_addr = '0;
    cfg_wdata = '0; out_ready = 1'b1;
    model_reset();
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_valid", out_valid, 0);
    check("rst_chan", out_chan, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_overrun", overrun, 0);

    // Default frame: both channels at phase 0, full amplitude sine
    start_frame(0, 0, 0, 0);
    collect_frame(0, 1);

    // Sine quadrants via channel 0 offset
    cfg_write(0, 1, 32'h4000_0000); start_frame(0, 0, 0, 0); collect_frame(0, 1);
    cfg_write(0, 1, 32'h8000_0000); start_frame(0, 0, 0, 0); collect_frame(0, 1);
    cfg_write(0, 1, 32'hC000_0000); start_frame(0, 0, 0, 0); collect_frame(0, 1);

    // Square at half amplitude, toggling every frame
    cfg_write(0, 1, 0);
    cfg_write(0, 2, 2); cfg_write(0, 3, 32'h8000); cfg_write(0, 0, 32'h8000_0000);
    repeat (2) begin start_frame(0, 0, 0, 0); collect_frame(0, 1); end

    // Saw ramp, then a tick coinciding with an increment change
    cfg_write(0, 2, 3); cfg_write(0, 3, 32'hFFFF); cfg_write(0, 0, 32'h0100_0000);
    repeat (2) begin start_frame(0, 0, 0, 0); collect_frame(0, 1); end
    start_frame(1, 0, 0, 32'h0200_0000); collect_frame(0, 1);
    start_frame(0, 0, 0, 0); collect_frame(0, 1);

    // Randomized configuration, idle gaps and backpressure
    for (int f = 0; f < 16; f++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++)
        cfg_write($urandom_range(0, 7), $urandom_range(0, 3), $urandom);
      repeat ($urandom_range(0, 3)) step();
      start_frame(0, 0, 0, 0);
      collect_frame(1, 0);
    end
    check("no_overrun_yet", overrun, 0);

    // Hold channel 0 in EMIT; a tick there is dropped and flags overrun;
    // a write to channel 1 not yet looked up still applies to this frame.
    out_ready = 1'b0;
    start_frame(0, 0, 0, 0);
    wait_valid("bp_wait");
    exp0 = model_sample(m_frame[0] + m_off[0], m_mode[0], m_amp[0]);
    for (int i = 0; i < 10; i++) begin
      check("bp_data", out_data, exp0);
      check("bp_chan", out_chan, 0);
      check("bp_valid", out_valid, 1);
      sample_tick = (i == 4);
      if (i == 2) begin
        cfg_we = 1'b1; cfg_chan = 3'd1; cfg_addr = 2'd1; cfg_wdata = 32'h4000_0000;
        model_write(1, 1, 32'h4000_0000);
      end
      step();
      sample_tick = 1'b0;
      cfg_we = 1'b0;
    end
    check("overrun_set", overrun, 1);
    collect_frame(0, 0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) extra++;
      step();
    end
    check("extra_frame", extra, 0);
    start_frame(0, 0, 0, 0); collect_frame(0, 1);
    check("overrun_sticky", overrun, 1);

    // Reset mid-EMIT together with an out-of-range write
    cfg_write(1, 2, 2);
    out_ready = 1'b0;
    start_frame(0, 0, 0, 0);
    wait_valid("rst_wait");
    reset = 1'b1; cfg_we = 1'b1; cfg_chan = 3'd5; cfg_addr = 2'd2; cfg_wdata = 0;
    step();
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_chan", out_chan, 0);
    check("midrst_overrun", overrun, 0);
    reset = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    model_reset();
    step();
    start_frame(0, 0, 0, 0); collect_frame(0, 1);

    // Non-default channel 1, then writes to nonexistent channels
    cfg_write(1, 2, 3); cfg_write(1, 0, 32'h1000_0000); cfg_write(1, 3, 32'h4321);
    for (int a = 0; a < 4; a++) begin
      cfg_write(5, a, $urandom);
      cfg_write(7, a, $urandom);
      cfg_write(3, a, $urandom);
    end
    repeat (2) begin start_frame(0, 0, 0, 0); collect_frame(0, 1); end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
